// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : stack_unit
// Purpose  : Operand stack for the stack-processor datapath. Accepts
//            push/pop/tos commands from the controller, keeps a registered
//            top-of-stack read result for the A register, and flags
//            overflow/underflow without disturbing stack state.
// Ports    : clk      - rising-edge clock
//            rst      - synchronous, active-high reset
//            push     - write din onto the stack
//            pop      - remove top entry, copy it to dout
//            tos      - copy top entry to dout, stack unchanged
//            din      - data to push [WIDTH]
//            dout     - registered read result [WIDTH]
//            count    - current number of entries [PTRW+1]
//            empty    - count == 0
//            full     - count == DEPTH
//            ovf_err  - push rejected because stack full
//            unf_err  - pop/tos rejected because stack empty
// Options  : STACK_ERR_STICKY_EN - when defined, ovf_err/unf_err hold at 1
//            once set until rst; otherwise they are one-cycle pulses.
// Revision : 1.0 - initial release
// ============================================================================
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     tos,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf_err,
    output logic                     unf_err
);

    localparam int              PTRW       = $clog2(DEPTH);
    localparam logic [PTRW:0]   C_FULL_CNT = (PTRW+1)'(DEPTH);

    // Storage has no reset: an entry is only read after it has been written.
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [PTRW:0]    r_sp;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic [PTRW:0]    w_sp_m1;
    logic [PTRW-1:0]  w_top_idx;
    logic [PTRW-1:0]  w_wr_idx;
    logic [WIDTH-1:0] w_top;

    logic [PTRW:0]    w_sp_nxt;
    logic             w_dout_ld;
    logic             w_mem_we;
    logic [PTRW-1:0]  w_mem_addr;
    logic             w_ovf_evt;
    logic             w_unf_evt;

    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == C_FULL_CNT);
    assign w_sp_m1   = r_sp - 1'b1;
    assign w_top_idx = w_sp_m1[PTRW-1:0];
    // When full the low bits wrap to 0, but a write is never issued then.
    assign w_wr_idx  = r_sp[PTRW-1:0];
    assign w_top     = r_mem[w_top_idx];

    // Command decode. A read (pop or tos) on an empty stack rejects the whole
    // command including any accompanying push. pop dominates tos.
    always_comb begin
        w_sp_nxt   = r_sp;
        w_dout_ld  = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = w_wr_idx;
        w_ovf_evt  = 1'b0;
        w_unf_evt  = 1'b0;

        if (pop || tos) begin
            if (w_empty) begin
                w_unf_evt = 1'b1;
            end else begin
                w_dout_ld = 1'b1;
                if (pop) begin
                    if (push) begin
                        // Replace top in place; legal even when full.
                        w_mem_we   = 1'b1;
                        w_mem_addr = w_top_idx;
                    end else begin
                        w_sp_nxt = w_sp_m1;
                    end
                end else if (push) begin
                    if (w_full) begin
                        w_ovf_evt = 1'b1;
                    end else begin
                        w_mem_we = 1'b1;
                        w_sp_nxt = r_sp + 1'b1;
                    end
                end
            end
        end else if (push) begin
            if (w_full) begin
                w_ovf_evt = 1'b1;
            end else begin
                w_mem_we = 1'b1;
                w_sp_nxt = r_sp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp   <= '0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_sp <= w_sp_nxt;
            if (w_dout_ld) begin
                r_dout <= w_top;
            end
`ifdef STACK_ERR_STICKY_EN
            r_ovf <= r_ovf | w_ovf_evt;
            r_unf <= r_unf | w_unf_evt;
`else
            r_ovf <= w_ovf_evt;
            r_unf <= w_unf_evt;
`endif
        end
    end

    // Gated by rst so a command coincident with reset leaves no trace.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_addr] <= din;
        end
    end

    assign dout    = r_dout;
    assign count   = r_sp;
    assign empty   = w_empty;
    assign full    = w_full;
    assign ovf_err = r_ovf;
    assign unf_err = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_unit
// Purpose  : Self-checking bench for stack_unit. A behavioural stack model
//            computes the expected outputs of each command; they are queued
//            when the command is driven and compared once the DUT has
//            clocked the command in.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int PTRW  = $clog2(DEPTH);

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             tos;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [PTRW:0]    count;
    logic             empty;
    logic             full;
    logic             ovf_err;
    logic             unf_err;

    stack_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .tos     (tos),
        .din     (din),
        .dout    (dout),
        .count   (count),
        .empty   (empty),
        .full    (full),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] dout;
        int               count;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t             sb_q[$];
    logic [WIDTH-1:0] model[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ovf;
    logic             m_unf;

    int n_checks;
    int n_errors;

`ifdef STACK_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare all observable outputs against the oldest queued expectation.
    task automatic compare_outputs(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard-empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " dout"},  32'(dout),    32'(e.dout));
        check({tag, " count"}, 32'(count),   32'(e.count));
        check({tag, " empty"}, 32'(empty),   32'(e.count == 0));
        check({tag, " full"},  32'(full),    32'(e.count == DEPTH));
        check({tag, " ovf"},   32'(ovf_err), 32'(e.ovf));
        check({tag, " unf"},   32'(unf_err), 32'(e.unf));
    endtask

    task automatic model_reset();
        model.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_cmd(input logic p, input logic po, input logic t,
                             input logic [WIDTH-1:0] d);
        logic ovf_evt;
        logic unf_evt;
        exp_t e;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (po || t) begin
            if (model.size() == 0) begin
                unf_evt = 1'b1;
            end else begin
                m_dout = model[model.size()-1];
                if (po) begin
                    if (p) model[model.size()-1] = d;
                    else   void'(model.pop_back());
                end else if (p) begin
                    if (model.size() < DEPTH) model.push_back(d);
                    else                      ovf_evt = 1'b1;
                end
            end
        end else if (p) begin
            if (model.size() < DEPTH) model.push_back(d);
            else                      ovf_evt = 1'b1;
        end
        m_ovf = STICKY ? (m_ovf | ovf_evt) : ovf_evt;
        m_unf = STICKY ? (m_unf | unf_evt) : unf_evt;
        e.dout  = m_dout;
        e.count = model.size();
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        sb_q.push_back(e);
    endtask

    // Drive one command for one clock, then compare 1 time unit after the edge.
    task automatic cmd(input string tag, input logic p, input logic po, input logic t,
                       input logic [WIDTH-1:0] d);
        model_cmd(p, po, t, d);
        push = p;
        pop  = po;
        tos  = t;
        din  = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        compare_outputs(tag);
    endtask

    // Reset, optionally with a command asserted at the same time.
    task automatic do_reset(input string tag, input logic p, input logic [WIDTH-1:0] d);
        exp_t e;
        model_reset();
        e.dout  = '0;
        e.count = 0;
        e.ovf   = 1'b0;
        e.unf   = 1'b0;
        sb_q.push_back(e);
        rst  = 1'b1;
        push = p;
        din  = d;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        push = 1'b0;
        compare_outputs(tag);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        tos  = 1'b0;
        din  = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset state
        do_reset("reset", 1'b0, '0);

        // Push three, tos
        cmd("t1 push11", 1, 0, 0, 8'h11);
        cmd("t1 push22", 1, 0, 0, 8'h22);
        cmd("t1 push33", 1, 0, 0, 8'h33);
        cmd("t1 tos",    0, 0, 1, 8'h00);

        // Pop down to empty, then underflow
        cmd("t2 pop1", 0, 1, 0, 8'h00);
        cmd("t2 pop2", 0, 1, 0, 8'h00);
        cmd("t2 pop3", 0, 1, 0, 8'h00);
        cmd("t2 pop_unf", 0, 1, 0, 8'h00);
        cmd("t2 tos_unf", 0, 0, 1, 8'h00);
        cmd("t2 push_pop_unf", 1, 1, 0, 8'hAA);
        cmd("t2 push_tos_unf", 1, 0, 1, 8'hBB);
        cmd("t2 idle", 0, 0, 0, 8'h00);

        // Fill, overflow, replace-top when full, push+tos when full
        do_reset("t3 reset", 1'b0, '0);
        for (int i = 1; i <= DEPTH; i++) cmd("t3 fill", 1, 0, 0, 8'(i));
        cmd("t3 push_ovf", 1, 0, 0, 8'h99);
        cmd("t3 push_pop_full", 1, 1, 0, 8'h5A);
        cmd("t3 push_tos_full", 1, 0, 1, 8'h6B);
        cmd("t3 pop", 0, 1, 0, 8'h00);
        cmd("t3 pop_tos", 0, 1, 1, 8'h00);

        // Replace top on a two-entry stack
        do_reset("t4 reset", 1'b0, '0);
        cmd("t4 push05", 1, 0, 0, 8'h05);
        cmd("t4 push07", 1, 0, 0, 8'h07);
        cmd("t4 push_pop", 1, 1, 0, 8'h0C);
        cmd("t4 tos", 0, 0, 1, 8'h00);
        cmd("t4 push_tos", 1, 0, 1, 8'h3C);
        cmd("t4 tos2", 0, 0, 1, 8'h00);

        // Reset in the middle of a push sequence
        do_reset("t5 reset", 1'b0, '0);
        for (int i = 0; i < 4; i++) cmd("t5 push", 1, 0, 0, 8'(8'h40 + i));
        cmd("t5 tos", 0, 0, 1, 8'h00);
        do_reset("t5 rst_with_push", 1'b1, 8'hEE);
        cmd("t5 tos_after", 0, 0, 1, 8'h00);

        // Error persistence (sticky or pulse depending on build)
        do_reset("t6 reset", 1'b0, '0);
        cmd("t6 pop_unf", 0, 1, 0, 8'h00);
        cmd("t6 push", 1, 0, 0, 8'h77);
        cmd("t6 pop", 0, 1, 0, 8'h00);
        cmd("t6 idle", 0, 0, 0, 8'h00);
        do_reset("t6 clear", 1'b0, '0);

        // Random command mix
        for (int i = 0; i < 200; i++) begin
            logic [2:0] c;
            c = 3'($urandom_range(0, 7));
            cmd("rand", c[0], c[1], c[2], 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
